display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (1 kHz slot at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, anti-ghosting dark cycles at the end of each slot.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, scan enable; 0 darkens the display.
REQ-006 SHALL have port value, input, 16, four hex digits; value[3:0] is the rightmost digit (index 0).
REQ-007 SHALL have port dp_mask, input, 4, decimal-point request per digit index; 1 lights the point.
REQ-008 SHALL have port digit, output, 4, nibble of the active digit, fed to the 7-segment decoder.
REQ-009 SHALL have port an, output, 4, active-low anode enables; an[i] drives digit i.
REQ-010 SHALL have port dp, output, 1, active-low decimal-point segment.

Function
REQ-011 SHALL implement states DARK, SHOW and GAP, plus a slot counter cnt (0..REFRESH_DIV-1), a digit index idx (0..3) and a 16-bit frame snapshot snap.
REQ-012 DARK: an=4'b1111, dp=1, cnt=0; when en=1 on an edge, load snap<=value, set idx=0 and cnt=0, and enter SHOW.
REQ-013 SHOW: an has only bit idx low, digit=snap[4*idx+3:4*idx], dp=~dp_mask[idx]; cnt increments each cycle.
REQ-014 SHOW SHALL last exactly REFRESH_DIV-BLANK_CYCLES cycles; on cnt==REFRESH_DIV-BLANK_CYCLES-1, enter GAP.
REQ-015 GAP: an=4'b1111, dp=1, digit held; on cnt==REFRESH_DIV-1, set cnt=0, set idx=(idx+1) mod 4, and enter SHOW.
REQ-016 On the GAP->SHOW transition where idx wraps 3->0, SHALL load snap<=value; a mid-frame change to value is not displayed until the next frame.
REQ-017 dp_mask is sampled live, not snapshotted.
REQ-018 en=0 in SHOW or GAP SHALL enter DARK on the next edge, so an=4'b1111 on that edge; re-enable always restarts at idx 0 with a fresh snapshot.
REQ-019 an, digit and dp SHALL be registers updated on the same edge as the state transition; no combinational path from inputs to outputs.
REQ-020 Parameter legality: BLANK_CYCLES>=1 and REFRESH_DIV>=BLANK_CYCLES+2; cnt is sized to clog2(REFRESH_DIV).
REQ-021 At most one an bit is low in any cycle; any state where an is low for two consecutive digits without an intervening GAP is an error.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock edge, force state=DARK, cnt=0, idx=0, snap=0, digit=0, an=4'b1111, dp=1.
REQ-023 A reset asserted mid-SHOW or mid-GAP SHALL abandon the frame; after release, operation resumes per REQ-012.

Configuration
REQ-024 Macro DISPLAY_SCAN_LZ_BLANK_EN: when defined, leading-zero blanking is enabled. A digit i in 1..3 whose nibble and all higher nibbles of snap are zero keeps an=4'b1111 and dp=1 during its SHOW slot, with timing unchanged. Digit 0 is always shown.
REQ-025 Without DISPLAY_SCAN_LZ_BLANK_EN, all four digits are always lit per REQ-013, and no blanking logic is synthesized.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-026 Reset release, en=1, value=16'h1234 -> 1 cycle after en, an=1110 with digit=4 for 6 cycles, then an=1111 for 2 cycles, then an=1101 with digit=3, then 1011 with digit=2, then 0111 with digit=1, repeating every 32 cycles.
REQ-027 Frame showing 16'h1234; value changes to 16'hABCD during idx=1 -> idx 2 and 3 still show 2 and 1; the next frame shows D, C, B, A.
REQ-028 dp_mask=4'b0100 -> dp=0 only during SHOW cycles of idx 2; dp=1 during all GAP and DARK cycles.
REQ-029 en dropped on the 3rd SHOW cycle of idx 2 -> an=1111 on the next edge; en re-raised -> restart at idx 0 with the current value.
REQ-030 rst_n pulsed low mid-GAP between clock edges -> an=1111, dp=1, digit=0 immediately, without a clock edge.
REQ-031 With DISPLAY_SCAN_LZ_BLANK_EN, value=16'h0070 -> an[3] and an[2] never low, an[1] low with digit=7, an[0] low with digit=0; value=16'h0000 -> only an[0] is ever low.

Source files
------------

// File: rtl/display_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with anti-ghosting gaps.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZ_BLANK_EN.
module display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] DARK = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   snap_reg, snap_next;

  logic [3:0]    sel_next;
  logic [3:0]    lit_mask;
  logic          show_next;
  logic [3:0]    an_next;
  logic [3:0]    digit_next;
  logic          dp_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    snap_next  = snap_reg;
    case (state_reg)
      DARK: begin
        cnt_next = '0;
        if (en) begin
          state_next = SHOW;
          idx_next   = 2'd0;
          snap_next  = value;
        end
      end
      SHOW: begin
        if (!en) begin
          state_next = DARK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == SHOW_LAST) state_next = GAP;
        end
      end
      GAP: begin
        if (!en) begin
          state_next = DARK;
          cnt_next   = '0;
        end else if (cnt_reg == SLOT_LAST) begin
          state_next = SHOW;
          cnt_next   = '0;
          idx_next   = idx_reg + 2'd1;
          // A new frame starts only when the scan wraps back to digit 0.
          if (idx_reg == 2'd3) snap_next = value;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = DARK;
        cnt_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign sel_next[gi] = (idx_next == 2'(gi));
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
      if (gi == 0) begin : g_always
        assign lit_mask[gi] = 1'b1;
      end else begin : g_lz
        // Lit only if this nibble or any higher one is non-zero.
        assign lit_mask[gi] = |snap_next[15:4*gi];
      end
`else
      assign lit_mask[gi] = 1'b1;
`endif
    end
  endgenerate

  // Outputs are computed from next-state values so they switch on the transition edge.
  assign show_next  = (state_next == SHOW);
  assign an_next    = show_next ? ~(sel_next & lit_mask) : 4'b1111;
  assign dp_next    = (show_next && lit_mask[idx_next]) ? ~dp_mask[idx_next] : 1'b1;
  assign digit_next = show_next ? snap_next[4*idx_next +: 4] : digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DARK;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
      snap_reg  <= 16'h0000;
      digit     <= 4'h0;
      an        <= 4'b1111;
      dp        <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      snap_reg  <= snap_next;
      digit     <= digit_next;
      an        <= an_next;
      dp        <= dp_next;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (REFRESH_DIV=8, BLANK_CYCLES=2) against a
// time-position reference model: each enabled cycle maps to frame/slot/offset arithmetic.
module tb_display_scan;

  localparam int RD  = 8;
  localparam int BC  = 2;
  localparam int FRM = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_active = 1'b0;
  int          m_n      = 0;
  logic [15:0] m_snap   = 16'h0;
  logic [3:0]  m_an     = 4'hf;
  logic [3:0]  m_digit  = 4'h0;
  logic        m_dp     = 1'b1;
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_mask(dp_mask),
    .digit(digit), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Expected outputs after one rising edge, from the inputs present at that edge.
  task automatic model_edge();
    int slot, pos;
    logic [15:0] upper;
    logic blank;
    if (!en) begin
      m_active = 1'b0;
      m_an = 4'hf;
      m_dp = 1'b1;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_n = 0;
      end else begin
        m_n++;
      end
      if (m_n % FRM == 0) m_snap = value;
      slot = (m_n % FRM) / RD;
      pos  = m_n % RD;
      if (pos < RD - BC) begin
        m_digit = 4'((m_snap >> (4 * slot)) & 16'hf);
        upper   = m_snap >> (4 * slot);
        blank   = LZ && (slot > 0) && (upper == 16'h0);
        m_an    = blank ? 4'hf : ~(4'b0001 << slot);
        m_dp    = blank ? 1'b1 : ~dp_mask[slot];
      end else begin
        m_an = 4'hf;
        m_dp = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag);
    n_assert++;
    assert (an === m_an) else begin
      n_fail++;
      $error("FAIL %s an: observed %b expected %b (t=%0t)", tag, an, m_an, $time);
    end
    n_assert++;
    assert (dp === m_dp) else begin
      n_fail++;
      $error("FAIL %s dp: observed %b expected %b (t=%0t)", tag, dp, m_dp, $time);
    end
    n_assert++;
    assert (digit === m_digit) else begin
      n_fail++;
      $error("FAIL %s digit: observed %h expected %h (t=%0t)", tag, digit, m_digit, $time);
    end
    n_assert++;
    assert ($countones(~an) <= 1) else begin
      n_fail++;
      $error("FAIL %s onehot: observed an=%b expected at most one low bit", tag, an);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    value   = 16'h0000;
    dp_mask = 4'b0000;

    // Reset state held across clock edges
    repeat (2) @(negedge clk);
    check("reset");
    rst_n = 1'b1;
    $display("step: reset released");
    run(3, "idle");

    // Basic scan of 1234
    value = 16'h1234;
    en    = 1'b1;
    step("first_show");
    n_assert++;
    assert (an === 4'b1110) else begin
      n_fail++;
      $error("FAIL first_an: observed %b expected 1110", an);
    end
    n_assert++;
    assert (digit === 4'h4) else begin
      n_fail++;
      $error("FAIL first_digit: observed %h expected 4", digit);
    end
    run(FRM + 4, "scan1234");
    $display("step: scan of 1234 done");

    // Mid-frame change during idx 1
    for (int i = 0; i < 2 * FRM && (m_n % FRM) != RD + 1; i++) step("sync_idx1");
    value = 16'hABCD;
    run(2 * FRM, "midframe");
    $display("step: mid-frame value change done");

    // Decimal point on idx 2 only
    dp_mask = 4'b0100;
    run(FRM + 3, "dpmask");
    dp_mask = 4'b0000;
    $display("step: dp_mask check done");

    // Drop en on the 3rd SHOW cycle of idx 2
    for (int i = 0; i < 2 * FRM && (m_n % FRM) != 2 * RD + 2; i++) step("sync_idx2");
    en = 1'b0;
    step("en_drop");
    n_assert++;
    assert (an === 4'b1111) else begin
      n_fail++;
      $error("FAIL en_drop_an: observed %b expected 1111", an);
    end
    run(3, "dark");
    value = 16'h5E6F;
    en = 1'b1;
    run(FRM + 2, "reenable");
    $display("step: enable drop and restart done");

    // Leading-zero patterns
    value = 16'h0070;
    run(2 * FRM, "lz0070");
    value = 16'h0000;
    run(2 * FRM, "lz0000");
    $display("step: leading-zero patterns done");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) en = ~en;
      step("random");
    end
    en = 1'b1;
    $display("step: random traffic done");

    // Asynchronous reset mid-GAP
    for (int i = 0; i < 4 * FRM && !(m_active && (m_n % RD) >= RD - BC); i++) step("sync_gap");
    #2;
    rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    m_an = 4'hf;
    m_dp = 1'b1;
    m_digit = 4'h0;
    check("async_reset");
    @(negedge clk);
    check("reset_hold");
    rst_n = 1'b1;
    value = 16'h9081;
    run(FRM + 4, "post_reset");
    $display("step: asynchronous reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
